wb_block_mover: RTL and testbench

- Wishbone-style bus initiator for the 8-bit data-memory bus (cyc/stb/we/ack, 8-bit address and data).
- On a start pulse it either copies LEN bytes from SRC to DST, or fills LEN bytes at DST with a constant.
- Sits beside the CPU on the data bus, behind the bus arbiter, so software or the UART path can offload bulk moves and buffer clears.
- Drives the same slave interface the data memory exposes: reads acknowledge one cycle after the strobe, writes acknowledge in the strobe cycle.

---
 rtl/wb_block_mover_if.sv | 23 ++
 rtl/wb_block_mover.sv | 142 ++++++++++++++
 tb/tb_wb_block_mover.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_block_mover_if.sv
// rtl/wb_block_mover_if.sv - Wishbone-style data-memory bus bundle for the block mover
interface wb_block_mover_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          cyc_o;
  logic          stb_o;
  logic          we_o;
  logic [AW-1:0] adr_o;
  logic [DW-1:0] dat_o;
  logic [DW-1:0] dat_i;
  logic          ack_i;

  modport master (
    output cyc_o, stb_o, we_o, adr_o, dat_o,
    input  dat_i, ack_i
  );

  modport slave (
    input  cyc_o, stb_o, we_o, adr_o, dat_o,
    output dat_i, ack_i
  );
endinterface

// File: rtl/wb_block_mover.sv
// rtl/wb_block_mover.sv - bus initiator that copies or fills a block of data memory
module wb_block_mover #(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              fill_i,
  input  logic [AW-1:0]     src_i,
  input  logic [AW-1:0]     dst_i,
  input  logic [AW-1:0]     len_i,
  input  logic [DW-1:0]     fill_dat_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  wb_block_mover_if.master  bus
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_GAP, S_FIN} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] src_q, dst_q, len_q;
  logic          fill_q;
  logic [DW-1:0] fill_dat_q, buf_q;
  logic [AW:0]   idx_q;       // one bit wider than len so a 255-byte job never wraps
  logic          last_rd_q;   // the transfer that led into GAP was a read
  logic [7:0]    to_cnt_q;
  logic          busy_q, done_q, err_q;

  logic accept, strobe, timed_out, at_end;

  assign accept    = (state_q == S_IDLE) && start_i;
  assign strobe    = (state_q == S_RD) || (state_q == S_WR);
  assign timed_out = strobe && !bus.ack_i && (to_cnt_q == TO_LAST);
  assign at_end    = (idx_q == {1'b0, len_q});

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign err_o  = err_q;

  // State register; reset abandons any job in flight without a done pulse
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state and bus drive; address/data only leave zero while strobing
  always_comb begin
    state_d    = state_q;
    bus.cyc_o  = 1'b0;
    bus.stb_o  = 1'b0;
    bus.we_o   = 1'b0;
    bus.adr_o  = '0;
    bus.dat_o  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (len_i == '0) state_d = S_FIN;
          else if (fill_i) state_d = S_WR;
          else             state_d = S_RD;
        end
      end
      S_RD: begin
        bus.cyc_o = 1'b1;
        bus.stb_o = 1'b1;
        bus.adr_o = src_q + idx_q[AW-1:0];
        if (bus.ack_i)      state_d = S_GAP;
        else if (timed_out) state_d = S_FIN;
      end
      S_WR: begin
        bus.cyc_o = 1'b1;
        bus.stb_o = 1'b1;
        bus.we_o  = 1'b1;
        bus.adr_o = dst_q + idx_q[AW-1:0];
        bus.dat_o = fill_q ? fill_dat_q : buf_q;
        if (bus.ack_i)      state_d = S_GAP;
        else if (timed_out) state_d = S_FIN;
      end
      S_GAP: begin
        // One idle cycle so the slave's registered read-ack cannot leak into the next strobe
        if (last_rd_q)   state_d = S_WR;
        else if (at_end) state_d = S_FIN;
        else if (fill_q) state_d = S_WR;
        else             state_d = S_RD;
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Job parameters, byte index, read buffer and status flags
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      fill_q     <= 1'b0;
      fill_dat_q <= '0;
      buf_q      <= '0;
      idx_q      <= '0;
      last_rd_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= (state_q == S_FIN);
      if (state_q == S_FIN) busy_q <= 1'b0;
      if (accept) begin
        src_q      <= src_i;
        dst_q      <= dst_i;
        len_q      <= len_i;
        fill_q     <= fill_i;
        fill_dat_q <= fill_dat_i;
        idx_q      <= '0;
        last_rd_q  <= 1'b0;
        err_q      <= 1'b0;
        busy_q     <= 1'b1;
      end
      if ((state_q == S_RD) && bus.ack_i) begin
        buf_q     <= bus.dat_i;
        last_rd_q <= 1'b1;
      end
      if ((state_q == S_WR) && bus.ack_i) begin
        idx_q     <= idx_q + (AW+1)'(1);
        last_rd_q <= 1'b0;
      end
      if (timed_out) err_q <= 1'b1;
    end
  end

  // Counts strobe cycles still waiting for an acknowledge
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                 to_cnt_q <= 8'd0;
    else if (strobe && !bus.ack_i && !timed_out) to_cnt_q <= to_cnt_q + 8'd1;
    else                                         to_cnt_q <= 8'd0;
  end

endmodule

// File: tb/tb_wb_block_mover.sv
// tb/tb_wb_block_mover.sv - self-checking bench for wb_block_mover against a data-memory model
module tb_wb_block_mover;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       start, fill, busy, done, err;
  logic [7:0] src, dst, len, fill_dat;

  wb_block_mover_if #(.AW(AW), .DW(DW)) bus ();

  wb_block_mover #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .fill_i(fill),
    .src_i(src), .dst_i(dst), .len_i(len), .fill_dat_i(fill_dat),
    .busy_o(busy), .done_o(done), .err_o(err), .bus(bus)
  );

  // Data-memory slave: read ack one cycle after strobe, write ack in the strobe cycle
  logic [7:0] mem [256];
  logic [7:0] shadow [256];
  logic [7:0] rd_dat;
  logic       rd_ack, no_ack, mem_init;

  function automatic logic [7:0] pat(input int k);
    logic [7:0] r;
    case (k)
      16: r = 8'hA1;
      17: r = 8'hB2;
      18: r = 8'hC3;
      default: r = 8'(k * 37 + 11);
    endcase
    return r;
  endfunction

  assign bus.ack_i = !no_ack && ((bus.cyc_o && bus.stb_o && bus.we_o) || rd_ack);
  assign bus.dat_i = rd_dat;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int k = 0; k < 256; k++) mem[k] <= pat(k);
    end else if (bus.cyc_o && bus.stb_o && bus.we_o && !no_ack) begin
      mem[bus.adr_o] <= bus.dat_o;
    end
    rd_ack <= bus.cyc_o && bus.stb_o && !bus.we_o && !rd_ack;
    rd_dat <= mem[bus.adr_o];
  end

  typedef struct packed { logic [7:0] adr; logic [7:0] dat; } wr_t;
  wr_t exp_q[$];

  typedef struct {
    logic       f;
    logic [7:0] s, d, l, fd;
    int         lat;
    int         stb;
  } vec_t;
  vec_t vecs[7];

  int   checks = 0, errors = 0;
  int   stb_cnt = 0, busy_cnt = 0, done_cnt = 0, gap_viol = 0, idle_viol = 0;
  logic prev_acked = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Every wait goes through here: sample at the falling edge and score the bus
  task automatic tick();
    wr_t w;
    @(negedge clk);
    if (bus.stb_o) stb_cnt++;
    if (busy)      busy_cnt++;
    if (done)      done_cnt++;
    if (prev_acked && bus.stb_o) gap_viol++;
    if (!bus.stb_o && (bus.cyc_o || bus.we_o || bus.adr_o != 0 || bus.dat_o != 0)) idle_viol++;
    if (bus.cyc_o && bus.stb_o && bus.we_o && bus.ack_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write actual=adr 0x%0h dat 0x%0h required=no write", bus.adr_o, bus.dat_o);
      end else begin
        w = exp_q.pop_front();
        chk("write_adr", bus.adr_o, w.adr);
        chk("write_dat", bus.dat_o, w.dat);
      end
    end
    prev_acked = bus.stb_o && bus.ack_i;
  endtask

  task automatic chk_mem(input string name);
    int bad = 0;
    for (int k = 0; k < 256; k++) if (mem[k] !== shadow[k]) bad++;
    chk(name, bad, 0);
  endtask

  task automatic run_job(input logic f, input logic [7:0] s, d, l, fd,
                         input int exp_lat, input logic exp_err,
                         input logic interfere, input int exp_stb);
    int lat, stb0, busy0;
    for (int k = 0; k < int'(l); k++) begin
      logic [7:0] a_s, a_d, v;
      wr_t w;
      a_s = s + 8'(k);
      a_d = d + 8'(k);
      v = f ? fd : shadow[a_s];
      if (!no_ack) begin
        shadow[a_d] = v;
        w.adr = a_d;
        w.dat = v;
        exp_q.push_back(w);
      end
    end
    tick();
    start = 1'b1; fill = f; src = s; dst = d; len = l; fill_dat = fd;
    stb0 = stb_cnt; busy0 = busy_cnt;
    tick();
    start = 1'b0;
    lat = 1;
    while (!done && lat < 2000) begin
      if (interfere && lat == 5) begin
        start = 1'b1; fill = 1'b1; src = 8'h00; dst = 8'h90; len = 8'd9; fill_dat = 8'h33;
      end else begin
        start = 1'b0;
      end
      tick();
      lat++;
    end
    start = 1'b0;
    chk("done_latency", lat, exp_lat);
    chk("err_at_done", err, exp_err);
    chk("busy_at_done", busy, 0);
    chk("busy_cycles", busy_cnt - busy0, exp_lat - 1);
    if (exp_stb >= 0) chk("stb_cycles", stb_cnt - stb0, exp_stb);
    tick();
    chk("done_one_cycle", done, 0);
    chk("writes_drained", exp_q.size(), 0);
    exp_q.delete();
    chk("gap_violations", gap_viol, 0);
    chk("idle_bus_nonzero", idle_viol, 0);
    chk_mem("mem_image");
  endtask

  initial begin
    int n, done0;
    start = 0; fill = 0; src = 0; dst = 0; len = 0; fill_dat = 0;
    no_ack = 1'b0; mem_init = 1'b1; rst_n = 1'b0;
    for (int k = 0; k < 256; k++) shadow[k] = pat(k);

    vecs[0] = '{1'b0, 8'h10, 8'h40, 8'd3,   8'h00, 17,   9};
    vecs[1] = '{1'b1, 8'h00, 8'hFE, 8'd3,   8'h5A, 8,    3};
    vecs[2] = '{1'b0, 8'h55, 8'h66, 8'd0,   8'h00, 2,    0};
    vecs[3] = '{1'b0, 8'h20, 8'h22, 8'd5,   8'h00, 27,   15};
    vecs[4] = '{1'b0, 8'hFD, 8'h03, 8'd4,   8'h00, 22,   12};
    vecs[5] = '{1'b1, 8'h00, 8'h30, 8'd1,   8'h00, 4,    1};
    vecs[6] = '{1'b0, 8'h80, 8'h00, 8'd255, 8'h00, 1277, 765};

    tick();
    chk("rst_ctrl", {busy, done, err, bus.cyc_o, bus.stb_o, bus.we_o}, 0);
    chk("rst_adr", bus.adr_o, 0);
    chk("rst_dat", bus.dat_o, 0);
    tick();
    mem_init = 1'b0;
    rst_n = 1'b1;
    tick();
    tick();

    for (int v = 0; v < 7; v++) begin
      run_job(vecs[v].f, vecs[v].s, vecs[v].d, vecs[v].l, vecs[v].fd,
              vecs[v].lat, 1'b0, 1'b0, vecs[v].stb);
      if (v == 0) begin
        chk("copy_0x40", mem[8'h40], 8'hA1);
        chk("copy_0x41", mem[8'h41], 8'hB2);
        chk("copy_0x42", mem[8'h42], 8'hC3);
      end
      if (v == 1) begin
        chk("fill_0xFE", mem[8'hFE], 8'h5A);
        chk("fill_0xFF", mem[8'hFF], 8'h5A);
        chk("fill_0x00", mem[8'h00], 8'h5A);
        chk("fill_0x01_untouched", mem[8'h01], pat(1));
      end
    end

    // Second start mid-copy must not disturb the running job
    run_job(1'b0, 8'h10, 8'h60, 8'd3, 8'h00, 17, 1'b0, 1'b1, 9);

    // Slave never acks: strobe for TIMEOUT cycles, then error
    no_ack = 1'b1;
    run_job(1'b0, 8'h05, 8'h50, 8'd2, 8'h00, 18, 1'b1, 1'b0, 16);
    no_ack = 1'b0;
    repeat (3) tick();
    chk("err_held", err, 1);
    run_job(1'b0, 8'h00, 8'h00, 8'd0, 8'h00, 2, 1'b0, 1'b0, 0);

    // Write timeout, then reset while idle clears the error
    no_ack = 1'b1;
    run_job(1'b1, 8'h00, 8'h50, 8'd2, 8'h77, 18, 1'b1, 1'b0, 16);
    no_ack = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_clears_err", err, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Reset during the write of index 2 of a 4-byte fill
    begin
      wr_t w;
      shadow[8'h80] = 8'hEE;
      shadow[8'h81] = 8'hEE;
      for (int k = 0; k < 3; k++) begin
        w.adr = 8'h80 + 8'(k);
        w.dat = 8'hEE;
        exp_q.push_back(w);
      end
    end
    tick();
    start = 1'b1; fill = 1'b1; src = 8'h00; dst = 8'h80; len = 8'd4; fill_dat = 8'hEE;
    done0 = done_cnt;
    tick();
    start = 1'b0;
    n = 0;
    while (!(bus.stb_o && bus.we_o && bus.adr_o == 8'h82) && n < 20) begin
      tick();
      n++;
    end
    chk("reached_third_write", bus.adr_o, 8'h82);
    rst_n = 1'b0;
    #1;
    chk("rstmid_ctrl", {busy, done, err, bus.cyc_o, bus.stb_o, bus.we_o}, 0);
    chk("rstmid_adr", bus.adr_o, 0);
    chk("rstmid_dat", bus.dat_o, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("rstmid_no_done", done_cnt - done0, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_writes_drained", exp_q.size(), 0);
    exp_q.delete();
    chk("rstmid_0x82_untouched", mem[8'h82], shadow[8'h82]);
    chk_mem("rstmid_mem_image");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
